// File: rtl/cfg_arb_pkg.sv
// Shared types and default widths for the config-space arbiter.
// The FSM state enum lives here so the arbiter and any monitors agree on the encoding.
package cfg_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins, and on a tie
// the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last_grant);
  assign gnt[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/cfg_space_arbiter.sv
// Arbitrates sideband (req0) and logical-layer FSM (req1) accesses onto a single
// config-space port with fixed-latency reads.
module cfg_space_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              sb_clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              c_read,
  output logic              c_write,
  output logic [ADDR_W-1:0] c_address,
  output logic [DATA_W-1:0] c_data_in,
  input  logic [DATA_W-1:0] c_data_out,
  output logic              busy
);

  // WAIT_RD always spends one cycle, then counts RD_LAT-1 more before sampling.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  arb_state_t       state;
  logic             wr_q;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0]       gnt;
  logic             accept;

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign req0_ready = (state == IDLE) & gnt[0];
  assign req1_ready = (state == IDLE) & gnt[1];
  assign accept     = req0_ready | req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rd_cnt      <= '0;
      c_read      <= 1'b0;
      c_write     <= 1'b0;
      c_address   <= '0;
      c_data_in   <= '0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      // NOTE: strobes and rvalid default low every cycle, so each set below is a
      // one-cycle pulse; non-blocking assignments keep all registers updating together.
      c_read      <= 1'b0;
      c_write     <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= gnt[1];
            last_grant <= gnt[1];
            wr_q       <= gnt[1] ? req1_write : req0_write;
            c_write    <= gnt[1] ? req1_write : req0_write;
            c_read     <= gnt[1] ? ~req1_write : ~req0_write;
            c_address  <= gnt[1] ? req1_addr : req0_addr;
            c_data_in  <= gnt[1] ? req1_wdata : req0_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rd_cnt <= '0;
          state  <= wr_q ? IDLE : WAIT_RD;
        end
        WAIT_RD: begin
          if (rd_cnt == LAST_CNT) begin
            if (owner) begin
              req1_rdata  <= c_data_out;
              req1_rvalid <= 1'b1;
            end else begin
              req0_rdata  <= c_data_out;
              req0_rvalid <= 1'b1;
            end
            state <= RESP;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_space_arbiter.sv
// Self-checking bench: grant table, directed latency/reset sequences, and a random
// run compared against a transaction-level timing model.
module tb_cfg_space_arbiter;

  localparam int RD_LAT_A = 2;
  localparam int NRAND    = 400;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [7:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic        c_read, c_write, busy;
  logic [7:0]  c_address;
  logic [31:0] c_data_in, c_data_out;

  logic        b_req0_valid, b_req0_write, b_req1_valid, b_req1_write;
  logic [7:0]  b_req0_addr, b_req1_addr;
  logic [31:0] b_req0_wdata, b_req1_wdata;
  logic        b_req0_ready, b_req0_rvalid, b_req1_ready, b_req1_rvalid;
  logic [31:0] b_req0_rdata, b_req1_rdata;
  logic        b_c_read, b_c_write, b_busy;
  logic [7:0]  b_c_address;
  logic [31:0] b_c_data_in, b_c_data_out;

  int passed = 0;
  int total  = 0;
  int excl_err = 0;

  always #5 sb_clk = ~sb_clk;

  cfg_space_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(RD_LAT_A)) dut (
    .sb_clk(sb_clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .c_read(c_read), .c_write(c_write), .c_address(c_address),
    .c_data_in(c_data_in), .c_data_out(c_data_out), .busy(busy)
  );

  cfg_space_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dut_lat1 (
    .sb_clk(sb_clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_write(b_req0_write), .req0_addr(b_req0_addr),
    .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready), .req0_rvalid(b_req0_rvalid),
    .req0_rdata(b_req0_rdata),
    .req1_valid(b_req1_valid), .req1_write(b_req1_write), .req1_addr(b_req1_addr),
    .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready), .req1_rvalid(b_req1_rvalid),
    .req1_rdata(b_req1_rdata),
    .c_read(b_c_read), .c_write(b_c_write), .c_address(b_c_address),
    .c_data_in(b_c_data_in), .c_data_out(b_c_data_out), .busy(b_busy)
  );

  // Read and write strobes must be mutually exclusive on both instances.
  always @(negedge sb_clk) begin
    assert (!(c_read && c_write) && !(b_c_read && b_c_write))
    else begin
      $display("FAIL strobe_exclusive: c_read/c_write both high at %0t", $time);
      excl_err++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_reqs();
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    b_req0_valid = 0; b_req0_write = 0; b_req0_addr = '0; b_req0_wdata = '0;
    b_req1_valid = 0; b_req1_write = 0; b_req1_addr = '0; b_req1_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] cfg_word(input int n);
    return 32'(n) * 32'h9E37_79B1 + 32'h0F0F_1234;
  endfunction

  typedef struct {
    int   pre;
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } vec_t;

  typedef struct {
    logic        v;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
  } pend_t;

  vec_t        vecs[8];
  pend_t       pend[2];
  logic        exp_rd[1024], exp_wr[1024], exp_rv0[1024], exp_rv1[1024];
  logic [7:0]  exp_addr[1024];
  logic [31:0] exp_data[1024], exp_rdata[1024];
  int          grants[6];

  initial begin
    int gcnt, silent, free_at, g, rd_at;
    logic mlast;
    logic [7:0]  m_addr;
    logic [31:0] m_data;

    rst = 1'b1;
    c_data_out = '0;
    b_c_data_out = '0;
    clear_reqs();

    // ---- reset state ----
    do_reset();
    settle();
    check("rst_busy", busy, 0);
    check("rst_c_read", c_read, 0);
    check("rst_c_write", c_write, 0);
    check("rst_c_address", c_address, 0);
    check("rst_c_data_in", c_data_in, 0);
    check("rst_rvalid", {req0_rvalid, req1_rvalid}, 0);
    check("rst_rdata", {req0_rdata, req1_rdata}, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);

    // ---- grant table: optional prior write sets last_grant ----
    vecs[0] = '{-1, 0, 0, 0, 0};
    vecs[1] = '{-1, 1, 0, 1, 0};
    vecs[2] = '{-1, 0, 1, 0, 1};
    vecs[3] = '{-1, 1, 1, 1, 0};
    vecs[4] = '{ 0, 1, 1, 0, 1};
    vecs[5] = '{ 1, 1, 1, 1, 0};
    vecs[6] = '{ 0, 1, 0, 1, 0};
    vecs[7] = '{ 1, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (vecs[i].pre == 0) begin
        req0_valid = 1; req0_write = 1;
        step(); clear_reqs(); step(); step();
      end else if (vecs[i].pre == 1) begin
        req1_valid = 1; req1_write = 1;
        step(); clear_reqs(); step(); step();
      end
      req0_valid = vecs[i].v0;
      req1_valid = vecs[i].v1;
      settle();
      check($sformatf("grant_vec%0d", i), {req0_ready, req1_ready}, {vecs[i].r0, vecs[i].r1});
    end

    // ---- req0 write 0x10 / 0xDEADBEEF ----
    do_reset();
    req0_valid = 1; req0_write = 1; req0_addr = 8'h10; req0_wdata = 32'hDEAD_BEEF;
    settle();
    check("wr_c0_ready", {req0_ready, req1_ready}, 2'b10);
    check("wr_c0_busy", busy, 0);
    step();
    clear_reqs();
    req1_valid = 1;
    settle();
    check("wr_c1_strobes", {c_write, c_read}, 2'b10);
    check("wr_c1_addr", c_address, 8'h10);
    check("wr_c1_data", c_data_in, 32'hDEAD_BEEF);
    check("wr_c1_busy", busy, 1);
    check("wr_c1_ready_blocked", req1_ready, 0);
    step();
    clear_reqs();
    settle();
    check("wr_c2_strobes", {c_write, c_read}, 2'b00);
    check("wr_c2_busy", busy, 0);
    check("wr_c2_addr_hold", c_address, 8'h10);

    // ---- req1 read 0x20, RD_LAT=2 ----
    do_reset();
    c_data_out = 32'h1234_5678;
    req1_valid = 1; req1_write = 0; req1_addr = 8'h20; req1_wdata = 32'h0;
    settle();
    check("rd_c0_ready1", {req0_ready, req1_ready}, 2'b01);
    step();
    clear_reqs();
    settle();
    check("rd_c1_strobes", {c_read, c_write}, 2'b10);
    check("rd_c1_addr", c_address, 8'h20);
    for (int c = 2; c <= 3; c++) begin
      step(); settle();
      check($sformatf("rd_c%0d_no_rvalid", c), {req0_rvalid, req1_rvalid, c_read}, 3'b000);
      check($sformatf("rd_c%0d_busy", c), busy, 1);
    end
    step(); settle();
    check("rd_c4_rvalid", {req0_rvalid, req1_rvalid}, 2'b01);
    check("rd_c4_rdata", req1_rdata, 32'h1234_5678);
    step(); settle();
    check("rd_c5_idle", {req1_rvalid, busy}, 2'b00);

    // ---- both valid continuously: grants must alternate ----
    do_reset();
    gcnt = 0;
    for (int c = 0; c < 40 && gcnt < 6; c++) begin
      req0_valid = 1; req0_write = 1; req0_addr = 8'(c);
      req1_valid = 1; req1_write = 1; req1_addr = 8'(c + 100);
      settle();
      if (req0_ready && req1_ready) check("rr_double_grant", 1, 0);
      if (req0_ready) begin grants[gcnt] = 0; gcnt++; end
      else if (req1_ready) begin grants[gcnt] = 1; gcnt++; end
      step();
    end
    clear_reqs();
    check("rr_grant_count", gcnt, 6);
    for (int k = 0; k < gcnt; k++) check($sformatf("rr_grant%0d", k), grants[k], k % 2);

    // ---- reset during WAIT_RD ----
    do_reset();
    c_data_out = 32'h5555_AAAA;
    req0_valid = 1; req0_write = 0; req0_addr = 8'h33;
    settle();
    check("rstw_c0_ready0", req0_ready, 1);
    step(); clear_reqs(); settle();
    check("rstw_c1_read", c_read, 1);
    step(); settle();
    check("rstw_c2_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("rstw_after_busy", busy, 0);
    check("rstw_after_strobes", {c_read, c_write}, 0);
    check("rstw_after_addr", c_address, 0);
    check("rstw_after_rdata", req0_rdata, 0);
    silent = 0;
    for (int c = 0; c < 6; c++) begin
      if (req0_rvalid || req1_rvalid || c_read || c_write) silent++;
      step(); settle();
    end
    check("rstw_no_late_activity", silent, 0);
    c_data_out = 32'hCAFE_F00D;
    req0_valid = 1; req0_write = 0; req0_addr = 8'h44;
    req1_valid = 1; req1_write = 0; req1_addr = 8'h45;
    settle();
    check("rstw_next_grant0", {req0_ready, req1_ready}, 2'b10);
    step(); req0_valid = 0; settle();
    check("rstw_next_read", {c_read, c_address}, {1'b1, 8'h44});
    step(); step(); step(); settle();
    check("rstw_next_rvalid", {req0_rvalid, req1_rvalid}, 2'b10);
    check("rstw_next_rdata", req0_rdata, 32'hCAFE_F00D);
    step(); clear_reqs(); step(); step(); step(); step(); step(); step();

    // ---- RD_LAT=1 instance ----
    do_reset();
    b_c_data_out = 32'h0BAD_CAFE;
    b_req0_valid = 1; b_req0_write = 0; b_req0_addr = 8'h5A;
    settle();
    check("lat1_c0_ready", b_req0_ready, 1);
    step(); b_req0_valid = 0; settle();
    check("lat1_c1_read", {b_c_read, b_c_address}, {1'b1, 8'h5A});
    step(); settle();
    check("lat1_c2_wait", {b_req0_rvalid, b_busy}, 2'b01);
    step(); settle();
    check("lat1_c3_rvalid", {b_req0_rvalid, b_req1_rvalid}, 2'b10);
    check("lat1_c3_rdata", b_req0_rdata, 32'h0BAD_CAFE);
    step(); settle();
    check("lat1_c4_idle", {b_req0_rvalid, b_busy}, 2'b00);

    // ---- random traffic vs transaction-level timing model ----
    for (int i = 0; i < 1024; i++) begin
      exp_rd[i] = 0; exp_wr[i] = 0; exp_rv0[i] = 0; exp_rv1[i] = 0;
      exp_addr[i] = '0; exp_data[i] = '0; exp_rdata[i] = '0;
    end
    for (int r = 0; r < 2; r++) pend[r] = '{1'b0, 1'b0, 8'h0, 32'h0};
    do_reset();
    free_at = 0; mlast = 1'b1; m_addr = '0; m_data = '0;
    for (int n = 0; n < NRAND; n++) begin
      c_data_out = cfg_word(n);
      for (int r = 0; r < 2; r++)
        if (!pend[r].v && $urandom_range(0, 2) != 0)
          pend[r] = '{1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom};
      req0_valid = pend[0].v; req0_write = pend[0].w; req0_addr = pend[0].a; req0_wdata = pend[0].d;
      req1_valid = pend[1].v; req1_write = pend[1].w; req1_addr = pend[1].a; req1_wdata = pend[1].d;
      settle();
      g = -1;
      if (n >= free_at) begin
        if (pend[0].v && pend[1].v) g = mlast ? 0 : 1;
        else if (pend[0].v) g = 0;
        else if (pend[1].v) g = 1;
      end
      if (exp_rd[n] || exp_wr[n]) begin m_addr = exp_addr[n]; m_data = exp_data[n]; end
      check("rnd_ready", {req0_ready, req1_ready}, {g == 0, g == 1});
      check("rnd_busy", busy, n < free_at);
      check("rnd_strobes", {c_read, c_write}, {exp_rd[n], exp_wr[n]});
      check("rnd_addr", c_address, m_addr);
      check("rnd_wdata", c_data_in, m_data);
      check("rnd_rvalid", {req0_rvalid, req1_rvalid}, {exp_rv0[n], exp_rv1[n]});
      if (exp_rv0[n]) check("rnd_rdata0", req0_rdata, exp_rdata[n]);
      if (exp_rv1[n]) check("rnd_rdata1", req1_rdata, exp_rdata[n]);
      if (g >= 0) begin
        exp_wr[n+1] = pend[g].w;
        exp_rd[n+1] = ~pend[g].w;
        exp_addr[n+1] = pend[g].a;
        exp_data[n+1] = pend[g].d;
        if (pend[g].w) begin
          free_at = n + 2;
        end else begin
          rd_at = n + 2 + RD_LAT_A;
          if (g == 0) exp_rv0[rd_at] = 1'b1; else exp_rv1[rd_at] = 1'b1;
          exp_rdata[rd_at] = cfg_word(n + 1 + RD_LAT_A);
          free_at = n + 3 + RD_LAT_A;
        end
        mlast = 1'(g);
        pend[g].v = 1'b0;
      end
      step();
    end
    clear_reqs();

    check("strobe_exclusive_count", excl_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cfg_space_arbiter.md
CFG_SPACE_ARBITER -- requirements
Module: cfg_space_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, config-space address width.
REQ-002 Parameter DATA_W, default 32, config-space data width.
REQ-003 Parameter RD_LAT, default 2, cycles from c_read strobe to valid c_data_out; legal range 1..15.
REQ-004 Port sb_clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port req0_valid / req1_valid  input  1  requester 0 (sideband register access) / requester 1 (logical-layer control FSM) has a pending access.
REQ-007 Port reqN_write  input  1  1 = write, 0 = read (N = 0,1).
REQ-008 Port reqN_addr  input  ADDR_W  access address.
REQ-009 Port reqN_wdata  input  DATA_W  write data.
REQ-010 Port reqN_ready  output  1  request accepted this cycle.
REQ-011 Port reqN_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-012 Port reqN_rdata  output  DATA_W  read data, qualified by reqN_rvalid.
REQ-013 Port c_read / c_write  output  1  config-space read/write strobes.
REQ-014 Port c_address  output  ADDR_W  config-space address.
REQ-015 Port c_data_in  output  DATA_W  write data to config space.
REQ-016 Port c_data_out  input  DATA_W  read data from config space.
REQ-017 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT_RD and RESP.
REQ-019 In IDLE, reqN_ready SHALL be asserted combinationally for exactly one granted requester with reqN_valid high; a request is accepted on valid&ready.
REQ-020 With both valid, the grant SHALL go to the requester not granted last (round-robin); with one valid, that requester SHALL be granted.
REQ-021 On accept, write flag, address and wdata SHALL be captured, owner recorded, last_grant updated, and the FSM SHALL move to ISSUE.
REQ-022 In ISSUE, exactly one of c_write/c_read SHALL be high for exactly one cycle, with c_address/c_data_in driven from the captured values.
REQ-023 After a write ISSUE the FSM SHALL return to IDLE; write latency is 1 cycle of strobe, and the next accept is possible in the following cycle.
REQ-024 After a read ISSUE the FSM SHALL enter WAIT_RD, where a 4-bit counter SHALL count RD_LAT-1 further cycles (zero cycles when RD_LAT=1); c_data_out SHALL be sampled RD_LAT cycles after the c_read cycle.
REQ-025 In RESP, the owner's reqN_rvalid SHALL pulse for one cycle with reqN_rdata = sampled data, after which the FSM SHALL return to IDLE; the non-owner's rvalid SHALL stay 0.
REQ-026 reqN_ready SHALL be 0 in every state other than IDLE; requesters hold valid and payload until ready.
REQ-027 c_address and c_data_in SHALL hold their last value when no strobe is active; c_read and c_write SHALL never be high simultaneously.
REQ-028 Back-to-back requests from the same single requester SHALL be served without starvation of the other.

Reset
REQ-029 When rst=1 at a clock edge, the FSM SHALL go to IDLE, c_read, c_write, reqN_ready, reqN_rvalid and busy SHALL be 0, c_address, c_data_in, reqN_rdata and the counter SHALL be 0, and last_grant SHALL be 1 (requester 0 wins first).
REQ-030 A reset asserted mid-access SHALL abort it without any further strobe or rvalid.

Structure
REQ-031 The FSM state enum and default ADDR_W/DATA_W constants SHALL live in the shared package cfg_arb_pkg.
REQ-032 The two-input round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last_grant; output gnt[1:0]).

Verification
REQ-033 Req0 write addr 0x10 data 0xDEADBEEF -> ready0 in cycle 0, c_write=1 with addr 0x10 and data 0xDEADBEEF in cycle 1, busy for 1 cycle.
REQ-034 Req1 read addr 0x20, config returns 0x12345678, RD_LAT=2 -> c_read in cycle 1, rvalid1 with 0x12345678 in cycle 4, rvalid0=0.
REQ-035 Both valid continuously after reset -> grants alternate 0,1,0,1; no two consecutive grants to the same requester.
REQ-036 rst pulsed while in WAIT_RD -> no rvalid, outputs 0 next cycle, the next request is served normally.
REQ-037 RD_LAT=1 read -> rvalid 2 cycles after c_read; c_read and c_write are never both high (assertion).
